// File: rtl/mux_pkg.sv
// Shared constants and helpers for the round-robin / direct channel mux.
package mux_pkg;
  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  // Index width for n items, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: first set request at or after ptr, wrapping.
// Latency: combinational. Backpressure: none; en=0 suppresses every grant.
// State: none, the rotation pointer lives in the caller.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]               req,
  input  logic [clog2_min1(N)-1:0]   ptr,
  input  logic                       en,
  output logic [N-1:0]               gnt_oh,
  output logic [clog2_min1(N)-1:0]   gnt_idx,
  output logic                       any
);
  localparam int AW = clog2_min1(N);

  int idx;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (en && !any && req[idx]) begin
        any         = 1'b1;
        gnt_oh[idx] = 1'b1;
        gnt_idx     = AW'(idx);
      end
    end
  end
endmodule

// File: rtl/mux_rr_n.sv
// N-channel valid/ready mux, direct (addr) or round-robin select, registered output.
// Latency: one cycle from input handshake to out_valid.
// Backpressure: out_valid && !out_ready holds the output and drops every in_ready.
module mux_rr_n
  import mux_pkg::*;
#(
  parameter int N     = 8,
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cs_n,
  input  logic                         mode,
  input  logic [clog2_min1(N)-1:0]     addr,
  input  logic [N*WIDTH-1:0]           in_data,
  input  logic [N-1:0]                 in_valid,
  output logic [N-1:0]                 in_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [clog2_min1(N)-1:0]     out_chan,
  output logic                         out_valid,
  input  logic                         out_ready
);
  localparam int AW = clog2_min1(N);

  logic [AW-1:0]    ptr;
  logic [N-1:0]     dir_oh;
  logic [N-1:0]     arb_oh;
  logic [AW-1:0]    arb_idx;
  logic             arb_any;
  logic [N-1:0]     sel_oh;
  logic             gnt_any;
  logic [AW-1:0]    gnt_idx;
  logic [WIDTH-1:0] sel_data;
  logic             load_en;
  logic             xfer;

  rr_arbiter #(.N(N)) u_arb (
    .req     (in_valid),
    .ptr     (ptr),
    .en      (mode == MODE_RR),
    .gnt_oh  (arb_oh),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  // Direct mode offers ready to the addressed channel whether or not it is valid;
  // an out-of-range addr yields an all-zero one-hot.
  always_comb begin
    dir_oh = '0;
    for (int i = 0; i < N; i++) begin
      dir_oh[i] = (int'(addr) == i);
    end
  end

  assign load_en = !cs_n && (!out_valid || out_ready);
  assign sel_oh  = (mode == MODE_RR) ? arb_oh  : dir_oh;
  assign gnt_any = (mode == MODE_RR) ? arb_any : |(dir_oh & in_valid);
  assign gnt_idx = (mode == MODE_RR) ? arb_idx : addr;
  assign xfer    = load_en && gnt_any;

  assign in_ready = (load_en && !rst) ? sel_oh : '0;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (sel_oh[i]) sel_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= '0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_chan  <= gnt_idx;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_data  <= '0;
      end
      if (xfer && mode == MODE_RR) begin
        ptr <= AW'((int'(arb_idx) + 1) % N);
      end
    end
  end
endmodule
